door_controller_timed: RTL and testbench
========================================

// Module: door_controller_timed
// PURPOSE
//  Next-generation garage/door motor controller: drives UP_M/DOWN_M from limit switches and a push-button.
//  Adds a motion timeout watchdog, obstruction reversal, optional timed auto-close and a latched fault state.
//  Sits between debounced switch inputs and the motor driver; one instance per door.
// PARAMETERS
//  MOVE_TIMEOUT  1024  max cycles a motor may run before a limit switch is hit (>=2)
//  HOLD_TIME     256   cycles door is held open before auto-close (>=1)
//  AUTO_CLOSE    1     1: UP_MAX in MV_UP enters HOLD_OPEN; 0: enters IDLE
// PORTS
//  CLK        in   1  system clock, all logic on rising edge
//  RST        in   1  synchronous, active-high reset
//  Activate   in   1  open/close request, level-sampled each cycle
//  UP_MAX     in   1  door fully open limit switch
//  DOWN_MAX   in   1  door fully closed limit switch
//  Obstruct   in   1  beam-break / obstruction sensor
//  Fault_Clr  in   1  clears latched fault
//  UP_M       out  1  raise motor enable
//  DOWN_M     out  1  lower motor enable
//  Fault      out  1  high while in FAULT
//  State      out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset: State=IDLE, timer=0, UP_M=DOWN_M=Fault=0; RST has priority over all inputs, mid-motion included.
//  Moore outputs decoded from state register: change one cycle after the causing input is sampled.
//  UP_M only in MV_UP, DOWN_M only in MV_DN, never both; Fault only in FAULT.
//  Sensor conflict = UP_MAX & DOWN_MAX; from any non-FAULT state -> FAULT (highest priority).
//  IDLE: Activate&DOWN_MAX -> MV_UP; Activate&UP_MAX -> MV_DN; Activate&!UP_MAX&!DOWN_MAX -> MV_DN (homing).
//  MV_UP: UP_MAX -> HOLD_OPEN (AUTO_CLOSE=1) or IDLE; else timer==MOVE_TIMEOUT-1 -> FAULT.
//  MV_DN: priority DOWN_MAX -> IDLE; Obstruct -> MV_UP (reversal); timer==MOVE_TIMEOUT-1 -> FAULT.
//  HOLD_OPEN: Obstruct clears timer, stays; Activate -> MV_DN; timer==HOLD_TIME-1 -> MV_DN.
//  FAULT: Fault_Clr & !conflict -> IDLE; all other inputs ignored.
//  Timer: width $clog2(max(MOVE_TIMEOUT,HOLD_TIME)); cleared on every state change, else +1, saturating.
//  Motor thus runs exactly MOVE_TIMEOUT cycles before FAULT if no limit switch arrives.
//  Simultaneous limit hit and timeout terminal count: limit wins.
//  Unused encodings -> IDLE next cycle, outputs 0.
// STRUCTURE
//  door_ctrl_pkg: state localparams IDLE=0, MV_UP=1, MV_DN=2, HOLD_OPEN=3, FAULT=4; STATE_W=3.
//  Sub-module door_timer: clear/enable up-counter with saturation and terminal-count compare input.
//  Top: state register, next-state logic, output decode.
// TESTING (MOVE_TIMEOUT=16, HOLD_TIME=8, AUTO_CLOSE=1)
//  RST=1 for 2 cycles with Activate=1, DOWN_MAX=1 -> State=IDLE, UP_M=DOWN_M=0; release -> UP_M=1 next cycle.
//  Open: UP_MAX after 5 cycles -> HOLD_OPEN; 8 cycles later DOWN_M=1; DOWN_MAX -> IDLE, DOWN_M=0.
//  Obstruct pulse during MV_DN -> next cycle UP_M=1, DOWN_M=0, timer restarted.
//  MV_UP with no UP_MAX -> UP_M high exactly 16 cycles, then Fault=1; Fault_Clr -> IDLE.
//  UP_MAX=DOWN_MAX=1 in MV_DN -> FAULT; Fault_Clr ignored until conflict removed.
//  Obstruct held in HOLD_OPEN for 20 cycles -> no close; release -> DOWN_M after 8 cycles.

Source files
------------

// File: rtl/door_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the timed door controller.
// The timer is sized to hold the larger of the two terminal counts.
package door_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        MV_UP     = 3'd1,
        MV_DN     = 3'd2,
        HOLD_OPEN = 3'd3,
        FAULT     = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int timer_width(input int move_timeout, input int hold_time);
        int w;
        w = $clog2(max_int(move_timeout, hold_time));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/door_timer.sv
// Clear/enable up-counter that saturates at all-ones.
// Asserts tc while the count equals the supplied terminal value.
module door_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == tc_val);

endmodule

// File: rtl/door_controller_timed.sv
// Door motor controller: limit-switch driven motion with timeout watchdog,
// obstruction reversal, timed auto-close and a latched fault state.
module door_controller_timed
    import door_ctrl_pkg::*;
#(
    parameter int MOVE_TIMEOUT = 1024,
    parameter int HOLD_TIME    = 256,
    parameter bit AUTO_CLOSE   = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Activate,
    input  logic               UP_MAX,
    input  logic               DOWN_MAX,
    input  logic               Obstruct,
    input  logic               Fault_Clr,
    output logic               UP_M,
    output logic               DOWN_M,
    output logic               Fault,
    output logic [STATE_W-1:0] State
);

    localparam int TW = timer_width(MOVE_TIMEOUT, HOLD_TIME);
    localparam logic [TW-1:0] MOVE_TC = TW'(MOVE_TIMEOUT - 1);
    localparam logic [TW-1:0] HOLD_TC = TW'(HOLD_TIME - 1);

    state_t        state_q;
    state_t        state_d;
    logic          up_m_q;
    logic          up_m_d;
    logic          down_m_q;
    logic          down_m_d;
    logic          fault_q;
    logic          fault_d;

    logic          conflict;
    logic          timer_clr;
    logic          timer_tc;
    logic [TW-1:0] timer_tc_val;
    logic [TW-1:0] timer_cnt;

    door_timer #(
        .W(TW)
    ) u_timer (
        .clk    (CLK),
        .rst    (RST),
        .clr    (timer_clr),
        .en     (1'b1),
        .tc_val (timer_tc_val),
        .cnt    (timer_cnt),
        .tc     (timer_tc)
    );

    // Limit switches take priority over a coincident timeout in every motion state.
    always_comb begin
        state_d  = state_q;
        conflict = UP_MAX & DOWN_MAX;
        case (state_q)
            IDLE: begin
                if (conflict) begin
                    state_d = FAULT;
                end else if (Activate) begin
                    state_d = DOWN_MAX ? MV_UP : MV_DN;
                end
            end
            MV_UP: begin
                if (conflict) begin
                    state_d = FAULT;
                end else if (UP_MAX) begin
                    state_d = AUTO_CLOSE ? HOLD_OPEN : IDLE;
                end else if (timer_tc) begin
                    state_d = FAULT;
                end
            end
            MV_DN: begin
                if (conflict) begin
                    state_d = FAULT;
                end else if (DOWN_MAX) begin
                    state_d = IDLE;
                end else if (Obstruct) begin
                    state_d = MV_UP;
                end else if (timer_tc) begin
                    state_d = FAULT;
                end
            end
            HOLD_OPEN: begin
                if (conflict) begin
                    state_d = FAULT;
                end else if (Obstruct) begin
                    state_d = HOLD_OPEN;
                end else if (Activate || timer_tc) begin
                    state_d = MV_DN;
                end
            end
            FAULT: begin
                if (Fault_Clr && !conflict) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        timer_clr    = (state_d != state_q) || ((state_q == HOLD_OPEN) && Obstruct);
        timer_tc_val = (state_q == HOLD_OPEN) ? HOLD_TC : MOVE_TC;

        up_m_d   = (state_d == MV_UP);
        down_m_d = (state_d == MV_DN);
        fault_d  = (state_d == FAULT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            up_m_q   <= 1'b0;
            down_m_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            up_m_q   <= up_m_d;
            down_m_q <= down_m_d;
            fault_q  <= fault_d;
        end
    end

    assign UP_M   = up_m_q;
    assign DOWN_M = down_m_q;
    assign Fault  = fault_q;
    assign State  = state_q;

endmodule

// File: tb/tb_door_controller_timed.sv
// Directed bench for door_controller_timed: each driven cycle queues the
// hand-computed state/outputs expected after the following rising edge.
module tb_door_controller_timed;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UP   = 3'd1;
    localparam logic [2:0] S_DN   = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_FLT  = 3'd4;
    localparam int W = 7;

    logic       clk;
    logic       rst;
    logic       activate;
    logic       up_max;
    logic       down_max;
    logic       obstruct;
    logic       fault_clr;
    logic       up_m;
    logic       down_m;
    logic       fault;
    logic [2:0] state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           tests_run;
    int           tests_failed;
    bit           stim_done;

    door_controller_timed #(
        .MOVE_TIMEOUT (16),
        .HOLD_TIME    (8),
        .AUTO_CLOSE   (1'b1)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .Activate  (activate),
        .UP_MAX    (up_max),
        .DOWN_MAX  (down_max),
        .Obstruct  (obstruct),
        .Fault_Clr (fault_clr),
        .UP_M      (up_m),
        .DOWN_M    (down_m),
        .Fault     (fault),
        .State     (state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: n cycles of fixed inputs, each expecting state st afterwards
    task automatic cyc(input int n, input logic r, input logic act, input logic upx,
                       input logic dnx, input logic obs, input logic clr,
                       input logic [2:0] st, input string nm);
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = r;
            activate  = act;
            up_max    = upx;
            down_max  = dnx;
            obstruct  = obs;
            fault_clr = clr;
            w = {1'b1, st, (st == S_UP), (st == S_DN), (st == S_FLT)};
            exp_q.push_back(w);
            name_q.push_back(nm);
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [W-1:0] w;
        logic [W-1:0] got;
        string        nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                w  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (w[W-1]) begin
                    tests_run++;
                    got = {1'b1, state, up_m, down_m, fault};
                    if (got !== w) begin
                        tests_failed++;
                        $display("FAIL %s: got state=%0d up=%b dn=%b fault=%b, want state=%0d up=%b dn=%b fault=%b",
                                 nm, got[5:3], got[2], got[1], got[0], w[5:3], w[2], w[1], w[0]);
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        stim_done    = 1'b0;
        rst = 1'b1; activate = 1'b0; up_max = 1'b0;
        down_max = 1'b0; obstruct = 1'b0; fault_clr = 1'b0;

        //   n  rst act up dn obs clr
        cyc(2,  1, 1, 0, 1, 0, 0, S_IDLE, "reset");
        cyc(1,  0, 1, 0, 1, 0, 0, S_UP,   "start_up");
        cyc(4,  0, 0, 0, 0, 0, 0, S_UP,   "moving_up");
        cyc(1,  0, 0, 1, 0, 0, 0, S_HOLD, "reach_top");
        cyc(7,  0, 0, 1, 0, 0, 0, S_HOLD, "hold");
        cyc(1,  0, 0, 0, 0, 0, 0, S_DN,   "auto_close");
        cyc(3,  0, 0, 0, 0, 0, 0, S_DN,   "moving_dn");
        cyc(1,  0, 0, 0, 1, 0, 0, S_IDLE, "reach_bottom");
        cyc(1,  0, 0, 0, 1, 0, 0, S_IDLE, "idle_stay");

        cyc(1,  0, 1, 0, 0, 0, 0, S_DN,   "homing");
        cyc(2,  0, 0, 0, 0, 0, 0, S_DN,   "homing_dn");
        cyc(1,  0, 0, 0, 0, 1, 0, S_UP,   "reversal");
        cyc(15, 0, 0, 0, 0, 0, 0, S_UP,   "up_no_limit");
        cyc(1,  0, 0, 0, 0, 0, 0, S_FLT,  "up_timeout");
        cyc(2,  0, 1, 0, 1, 1, 0, S_FLT,  "fault_latched");
        cyc(1,  0, 0, 0, 1, 0, 1, S_IDLE, "fault_clear");

        cyc(1,  0, 1, 1, 0, 0, 0, S_DN,   "close_from_top");
        cyc(1,  0, 0, 1, 1, 0, 0, S_FLT,  "conflict");
        cyc(2,  0, 0, 1, 1, 0, 1, S_FLT,  "clr_blocked");
        cyc(1,  0, 0, 0, 1, 0, 1, S_IDLE, "clr_ok");

        cyc(1,  0, 1, 0, 1, 0, 0, S_UP,   "open2");
        cyc(1,  0, 0, 1, 0, 0, 0, S_HOLD, "top2");
        cyc(20, 0, 0, 1, 0, 1, 0, S_HOLD, "obstruct_hold");
        cyc(7,  0, 0, 1, 0, 0, 0, S_HOLD, "hold_after_obs");
        cyc(1,  0, 0, 1, 0, 0, 0, S_DN,   "close_after_obs");
        cyc(1,  0, 0, 0, 1, 0, 0, S_IDLE, "bottom2");

        cyc(1,  0, 1, 0, 1, 0, 0, S_UP,   "open3");
        cyc(15, 0, 0, 0, 0, 0, 0, S_UP,   "up_long");
        cyc(1,  0, 0, 1, 0, 0, 0, S_HOLD, "limit_beats_timeout");
        cyc(1,  0, 1, 1, 0, 0, 0, S_DN,   "activate_close");
        cyc(1,  0, 0, 0, 1, 1, 0, S_IDLE, "dnmax_beats_obs");

        cyc(1,  0, 1, 0, 1, 0, 0, S_UP,   "open4");
        cyc(1,  1, 1, 0, 1, 0, 0, S_IDLE, "reset_mid_motion");
        cyc(1,  0, 0, 0, 0, 0, 0, S_IDLE, "idle_after_rst");

        stim_done = 1'b1;
    end

    // final report
    initial begin
        int guard;
        guard = 0;
        while (!stim_done && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        if (!stim_done || exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: stim_done=%b pending=%0d, want stim_done=1 pending=0",
                     stim_done, exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
